// File: rtl/iboot_rom_asmi_pkg.sv
// rtl/iboot_rom_asmi_pkg.sv - shared types and constants for the ASMI burst reader
package iboot_rom_asmi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    localparam int ASMI_AW = 24;
    localparam logic [ASMI_AW-1:0] BASE_DEFAULT = 24'h400000;

endpackage

// File: rtl/iboot_rom_sync_fifo.sv
// rtl/iboot_rom_sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module iboot_rom_sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          iCLOCK_ASMI,
    input  logic          inRESET,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer and occupancy tracking; push+pop together leaves count unchanged even when full.
    always_ff @(posedge iCLOCK_ASMI or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; a head popped in the same cycle it is overwritten was already read out.
    always_ff @(posedge iCLOCK_ASMI) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/iboot_rom_asmi_burst_reader.sv
// rtl/iboot_rom_asmi_burst_reader.sv - ASMI segmented burst reader with output FIFO (option: IBOOT_ROM_ASMI_TIMEOUT_EN)
module iboot_rom_asmi_burst_reader
    import iboot_rom_asmi_pkg::*;
#(
    parameter int AN      = 23,
    parameter int DN      = 32,
    parameter int LEN_N   = 8,
    parameter logic [ASMI_AW-1:0] BASE = BASE_DEFAULT,
    parameter int QUEUE   = 8,
    parameter int QUEUE_N = 3,
    parameter int TMO_N   = 16
) (
    input  logic               iCLOCK_ASMI,
    input  logic               inRESET,
    input  logic               iRESET_SYNC,
    input  logic               iRQ_REQ,
    output logic               oRQ_BUSY,
    input  logic [AN-1:0]      iRQ_ADDR,
    input  logic [LEN_N-1:0]   iRQ_LEN,
    output logic [ASMI_AW-1:0] oASMI_ADDR,
    output logic               oASMI_READ,
    output logic               oASMI_RDEN,
    input  logic               iASMI_BUSY,
    input  logic               iASMI_DATA_VALID,
    input  logic [7:0]         iASMI_DATA,
    output logic               oRD_VALID,
    input  logic               iRD_BUSY,
    output logic [DN-1:0]      oRD_DATA,
    output logic               oRD_LAST,
    output logic               oERR_TIMEOUT
);

    localparam int BPW  = DN / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

    state_t             state;
    logic [AN-1:0]      addr;
    logic [LEN_N:0]     remaining;
    logic [QUEUE_N:0]   seg_words;
    logic [BC_W-1:0]    byte_cnt;
    logic [DN-1:0]      word_buf;
    logic               rq_busy;
    logic [ASMI_AW-1:0] asmi_addr;
    logic               asmi_read;
    logic               asmi_rden;

    logic [QUEUE_N:0]   fifo_count;
    logic [DN:0]        fifo_head;
    logic [QUEUE_N:0]   free_slots;
    logic [QUEUE_N:0]   seg_len;
    logic               byte_in;
    logic               word_done;
    logic [DN-1:0]      word_next;
    logic [DN:0]        push_data;
    logic               pop;
    logic               timeout_hit;

    // Credit and byte-lane assembly: a segment never asks for more words than the FIFO can hold.
    always_comb begin
        free_slots = (QUEUE_N+1)'(QUEUE) - fifo_count;
        if (int'(remaining) < int'(free_slots)) begin
            seg_len = (QUEUE_N+1)'(remaining);
        end else begin
            seg_len = free_slots;
        end
        byte_in   = (state == ST_STREAM) && iASMI_DATA_VALID;
        word_done = byte_in && (byte_cnt == BC_W'(BPW - 1));
        word_next = word_buf | (DN'(iASMI_DATA) << {byte_cnt, 3'b000});
        push_data = {(remaining == (LEN_N+1)'(1)), word_next};
        pop       = (fifo_count != '0) && !iRD_BUSY;
    end

`ifdef IBOOT_ROM_ASMI_TIMEOUT_EN
    logic [TMO_N-1:0] tmo_cnt;
    logic             err_timeout;

    assign timeout_hit = (state == ST_STREAM) && !iASMI_DATA_VALID &&
                         (tmo_cnt == {{(TMO_N-1){1'b1}}, 1'b0});
    assign oERR_TIMEOUT = err_timeout;

    // Idle-cycle counter for STREAM; the flag stays set until a reset.
    always_ff @(posedge iCLOCK_ASMI or negedge inRESET) begin
        if (!inRESET) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else if (iRESET_SYNC) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state != ST_STREAM || iASMI_DATA_VALID) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign oERR_TIMEOUT = 1'b0;
`endif

    // Request/segment sequencer with registered ASMI handshake outputs.
    always_ff @(posedge iCLOCK_ASMI or negedge inRESET) begin
        if (!inRESET) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            seg_words <= '0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            rq_busy   <= 1'b0;
            asmi_addr <= BASE;
            asmi_read <= 1'b0;
            asmi_rden <= 1'b0;
        end else if (iRESET_SYNC) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            seg_words <= '0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            rq_busy   <= 1'b0;
            asmi_addr <= BASE;
            asmi_read <= 1'b0;
            asmi_rden <= 1'b0;
        end else begin
            asmi_read <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iRQ_REQ) begin
                        addr      <= iRQ_ADDR;
                        remaining <= {1'b0, iRQ_LEN} + 1'b1;
                        rq_busy   <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (seg_len != '0 && !iASMI_BUSY) begin
                        seg_words <= seg_len;
                        asmi_addr <= BASE + ASMI_AW'(addr);
                        asmi_read <= 1'b1;
                        asmi_rden <= 1'b1;
                        byte_cnt  <= '0;
                        word_buf  <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (timeout_hit) begin
                        asmi_rden <= 1'b0;
                        remaining <= '0;
                        seg_words <= '0;
                        byte_cnt  <= '0;
                        word_buf  <= '0;
                        rq_busy   <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (word_done) begin
                        byte_cnt  <= '0;
                        word_buf  <= '0;
                        addr      <= addr + AN'(BPW);
                        remaining <= remaining - 1'b1;
                        seg_words <= seg_words - 1'b1;
                        if (seg_words == (QUEUE_N+1)'(1)) begin
                            asmi_rden <= 1'b0;
                            if (remaining == (LEN_N+1)'(1)) begin
                                rq_busy <= 1'b0;
                                state   <= ST_IDLE;
                            end else begin
                                state   <= ST_SETUP;
                            end
                        end
                    end else if (byte_in) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        word_buf <= word_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    iboot_rom_sync_fifo #(
        .W     (DN + 1),
        .DEPTH (QUEUE),
        .AW    (QUEUE_N)
    ) u_fifo (
        .iCLOCK_ASMI (iCLOCK_ASMI),
        .inRESET     (inRESET),
        .flush       (iRESET_SYNC),
        .push        (word_done && !timeout_hit),
        .push_data   (push_data),
        .pop         (pop),
        .head_data   (fifo_head),
        .count       (fifo_count)
    );

    assign oRQ_BUSY   = rq_busy;
    assign oASMI_ADDR = asmi_addr;
    assign oASMI_READ = asmi_read;
    assign oASMI_RDEN = asmi_rden;
    assign oRD_VALID  = (fifo_count != '0);
    assign oRD_DATA   = oRD_VALID ? fifo_head[DN-1:0] : '0;
    assign oRD_LAST   = oRD_VALID ? fifo_head[DN] : 1'b0;

endmodule

// File: tb/tb_iboot_rom_asmi_burst_reader.sv
// tb/tb_iboot_rom_asmi_burst_reader.sv - scoreboard bench for the ASMI burst reader (option: IBOOT_ROM_ASMI_TIMEOUT_EN)
`timescale 1ns/1ps
module tb_iboot_rom_asmi_burst_reader;

    localparam int AN = 23, DN = 32, LEN_N = 8, QUEUE = 8, QUEUE_N = 3;
`ifdef IBOOT_ROM_ASMI_TIMEOUT_EN
    localparam int TMO_N = 4;
`else
    localparam int TMO_N = 16;
`endif
    localparam logic [23:0] BASE = 24'h400000;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              rsync = 1'b0;
    logic              rq_req = 1'b0;
    logic              rq_busy;
    logic [AN-1:0]     rq_addr = '0;
    logic [LEN_N-1:0]  rq_len = '0;
    logic [23:0]       asmi_addr;
    logic              asmi_read, asmi_rden;
    logic              asmi_busy = 1'b0;
    logic              asmi_dv = 1'b0;
    logic [7:0]        asmi_data = '0;
    logic              rd_valid;
    logic              rd_busy = 1'b1;
    logic [DN-1:0]     rd_data;
    logic              rd_last;
    logic              err_tmo;

    iboot_rom_asmi_burst_reader #(
        .AN(AN), .DN(DN), .LEN_N(LEN_N), .BASE(BASE),
        .QUEUE(QUEUE), .QUEUE_N(QUEUE_N), .TMO_N(TMO_N)
    ) dut (
        .iCLOCK_ASMI      (clk),
        .inRESET          (nrst),
        .iRESET_SYNC      (rsync),
        .iRQ_REQ          (rq_req),
        .oRQ_BUSY         (rq_busy),
        .iRQ_ADDR         (rq_addr),
        .iRQ_LEN          (rq_len),
        .oASMI_ADDR       (asmi_addr),
        .oASMI_READ       (asmi_read),
        .oASMI_RDEN       (asmi_rden),
        .iASMI_BUSY       (asmi_busy),
        .iASMI_DATA_VALID (asmi_dv),
        .iASMI_DATA       (asmi_data),
        .oRD_VALID        (rd_valid),
        .iRD_BUSY         (rd_busy),
        .oRD_DATA         (rd_data),
        .oRD_LAST         (rd_last),
        .oERR_TIMEOUT     (err_tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DN-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    int          bytes_sent = 0;
    int          byte_limit = -1;
    int          read_cnt = 0;
    logic [23:0] last_seg_addr = '0;
    int          junk_n = 0;
    int          junk_done = 0;
    logic        rd_hold = 1'b1;

    // Flash content: a fixed hash of the absolute flash byte address.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [7:0]  n, lo, t8, hi;
        logic [19:0] t;
        n  = {4'd0, a[3:0]} + 8'd1;
        lo = n * 8'd17;
        t  = a[23:4] - 20'h40001;
        t8 = t[7:0];
        hi = t8 * 8'h5D;
        return lo ^ hi;
    endfunction

    // Word i of a request starting at byte offset start, little-endian, offset wrapping mod 2^AN.
    function automatic logic [DN-1:0] exp_word(input logic [AN-1:0] start, input int i);
        logic [DN-1:0] w;
        logic [AN-1:0] off;
        w = '0;
        for (int k = 0; k < DN/8; k++) begin
            off = start + AN'(i * (DN/8) + k);
            w[8*k +: 8] = flash_byte(BASE + {1'b0, off});
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int c;
        c = 0;
        while (rq_busy && c < bound) begin
            tick(1);
            c++;
        end
        if (rq_busy) check(name, 64'd1, 64'd0);
    endtask

    task automatic wait_drain(input int bound, input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            tick(1);
            c++;
        end
        if (exp_q.size() != 0) check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Issue a request; nexp expected words (of len+1) go to the scoreboard.
    task automatic issue(input logic [AN-1:0] a, input int len, input int nexp);
        wait_idle(3000, "issue_wait_idle");
        for (int i = 0; i < nexp; i++) begin
            exp_q.push_back('{data: exp_word(a, i), last: (i == len)});
        end
        rq_addr = a;
        rq_len  = LEN_N'(len);
        rq_req  = 1'b1;
        tick(1);
        rq_req  = 1'b0;
    endtask

    // Flash responder: skips the READ cycle, then streams bytes with random gaps while RDEN is high.
    logic [23:0] cur_addr;
    initial begin
        cur_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            asmi_dv   = 1'b0;
            asmi_data = 8'($urandom);
            asmi_busy = !asmi_rden && ($urandom_range(0, 2) == 0);
            if (asmi_read) begin
                cur_addr      = asmi_addr;
                last_seg_addr = asmi_addr;
                read_cnt++;
            end else if (asmi_rden && (byte_limit < 0 || bytes_sent < byte_limit)
                         && $urandom_range(0, 3) != 0) begin
                asmi_dv   = 1'b1;
                asmi_data = flash_byte(cur_addr);
                cur_addr  = cur_addr + 24'd1;
                bytes_sent++;
            end else if (!asmi_rden && junk_done < junk_n) begin
                asmi_dv   = 1'b1;
                asmi_data = 8'hEE;
                junk_done++;
            end
        end
    end

    // Consumer: stalls on hold, otherwise randomly.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rd_busy = rd_hold || ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: every pop is compared with the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (nrst && !rsync && rd_valid && !rd_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 64'(rd_data), 64'(e.data));
                    check("rd_last", 64'(rd_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        int r0, b0, c;
        logic [AN-1:0] a;

        tick(3);
        nrst = 1'b1;
        tick(1);
        check("rst_busy", 64'(rq_busy), 64'd0);
        check("rst_asmi_addr", 64'(asmi_addr), 64'h400000);
        check("rst_read", 64'(asmi_read), 64'd0);
        check("rst_rden", 64'(asmi_rden), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_err", 64'(err_tmo), 64'd0);

        // Single word: address and byte packing
        rd_hold = 1'b1;
        r0 = read_cnt;
        issue(AN'(32'h10), 0, 1);
        c = 0;
        while (!rd_valid && c < 200) begin tick(1); c++; end
        check("t1_data", 64'(rd_data), 64'h44332211);
        check("t1_last", 64'(rd_last), 64'd1);
        check("t1_reads", 64'(read_cnt - r0), 64'd1);
        check("t1_seg_addr", 64'(last_seg_addr), 64'h400010);
        rd_hold = 1'b0;
        wait_drain(200, "t1_drain");

        // 20 words with stalled consumer: one full-FIFO segment, then SETUP waits
        rd_hold = 1'b1;
        r0 = read_cnt;
        a = AN'($urandom);
        issue(a, 19, 20);
        tick(300);
        check("t2_reads_stalled", 64'(read_cnt - r0), 64'd1);
        check("t2_busy_stalled", 64'(rq_busy), 64'd1);
        check("t2_rden_stalled", 64'(asmi_rden), 64'd0);
        rd_hold = 1'b0;
        wait_idle(3000, "t2_idle");
        wait_drain(500, "t2_drain");
        check("t2_reads_ge3", 64'(read_cnt - r0 >= 3), 64'd1);

        // Request while busy and bytes while idle are ignored
        issue(AN'($urandom), 5, 6);
        tick(3);
        check("t3_busy", 64'(rq_busy), 64'd1);
        rq_addr = AN'($urandom);
        rq_len  = 8'd3;
        rq_req  = 1'b1;
        tick(1);
        rq_req  = 1'b0;
        wait_idle(1000, "t3_idle");
        junk_n = junk_n + 6;
        tick(20);
        wait_drain(300, "t3_drain");
        tick(10);
        check("t3_no_extra", 64'(rd_valid), 64'd0);

        // Synchronous reset partway into word 3
        rd_hold = 1'b1;
        b0 = bytes_sent;
        issue(AN'($urandom), 7, 0);
        c = 0;
        while (bytes_sent - b0 < 10 && c < 500) begin tick(1); c++; end
        tick(1);
        rsync = 1'b1;
        tick(1);
        rsync = 1'b0;
        check("t4_fifo_empty", 64'(rd_valid), 64'd0);
        check("t4_rden", 64'(asmi_rden), 64'd0);
        check("t4_idle", 64'(rq_busy), 64'd0);
        rd_hold = 1'b0;
        tick(20);
        issue(AN'($urandom), 2, 3);
        wait_idle(1000, "t4_idle2");
        wait_drain(300, "t4_drain");

        // Address wrap across a segment boundary
        rd_hold = 1'b1;
        issue(AN'(32'h100), 6, 7);
        wait_idle(1000, "t5_fill");
        r0 = read_cnt;
        issue(AN'((1 << AN) - 4), 1, 2);
        tick(100);
        check("t5_reads_stalled", 64'(read_cnt - r0), 64'd1);
        check("t5_first_addr", 64'(last_seg_addr), 64'hBFFFFC);
        rd_hold = 1'b0;
        wait_idle(1000, "t5_idle");
        check("t5_wrap_addr", 64'(last_seg_addr), 64'h400000);
        wait_drain(300, "t5_drain");

        // Random back-to-back requests
        for (int n = 0; n < 8; n++) begin
            int len;
            len = $urandom_range(0, 20);
            issue(AN'($urandom), len, len + 1);
        end
        wait_idle(5000, "rnd_idle");
        wait_drain(2000, "rnd_drain");

`ifdef IBOOT_ROM_ASMI_TIMEOUT_EN
        // Bytes stop mid-word 3: timeout, earlier words kept
        rd_hold = 1'b1;
        b0 = bytes_sent;
        byte_limit = b0 + 10;
        issue(AN'($urandom), 3, 2);
        c = 0;
        while (bytes_sent < byte_limit && c < 500) begin tick(1); c++; end
        tick(8);
        check("tmo_not_early", 64'(err_tmo), 64'd0);
        c = 0;
        while (!err_tmo && c < 100) begin tick(1); c++; end
        check("tmo_flag", 64'(err_tmo), 64'd1);
        check("tmo_idle", 64'(rq_busy), 64'd0);
        check("tmo_rden", 64'(asmi_rden), 64'd0);
        check("tmo_words_kept", 64'(rd_valid), 64'd1);
        byte_limit = -1;
        rd_hold = 1'b0;
        wait_drain(300, "tmo_drain");
        tick(10);
        check("tmo_sticky", 64'(err_tmo), 64'd1);
`else
        check("tmo_tied_low", 64'(err_tmo), 64'd0);
`endif

        tick(20);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_rd_valid", 64'(rd_valid), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
